sbus_uart_rx: RTL
=================

# sbus_uart_rx

Oversampling UART receiver for the S.BUS input, 100 kbaud 8E2 with inverted line by default. It synchronises the raw pin and recovers bytes with parity and stop-bit checking. It also detects BREAK conditions. It sits directly upstream of the byte monitor and the S.BUS frame assembler, driving the shared `uart_rx_data` / `uart_rx_valid` / `uart_rx_break` bus.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BIT_RATE`, 100_000: line bit rate. `CYCLES_PER_BIT = CLK_HZ/BIT_RATE` (integer division; 500 at defaults).
- `PAYLOAD_BITS`, 8: data bits per character, LSB first.
- `STOP_BITS`, 2: stop bits checked per character (1 or 2).
- `PARITY`, 2: 0 = none, 1 = odd, 2 = even.
- `RX_INVERT`, 1: 1 = pin idles low and is inverted before decoding (S.BUS).
- `IDLE_BITS`, 2: bit times of continuous idle required in WAIT_IDLE before a new start is accepted.

Ports:
- `clk`  in  1: top-level system clock.
- `sw_0`  in  1: reset, asynchronous, active-low.
- `uart_rxd`  in  1: raw asynchronous serial pin.
- `uart_rx_data`  out  PAYLOAD_BITS: last received character. Held until the next valid.
- `uart_rx_valid`  out  1: one-cycle pulse when `uart_rx_data` is updated.
- `uart_rx_break`  out  1: one-cycle pulse on BREAK detection.
- `uart_rx_parity_err`  out  1: coincident with `uart_rx_valid`. High if parity mismatched.
- `uart_rx_frame_err`  out  1: one-cycle pulse on a bad stop bit (non-break).

## Operation
- The pin passes through a 2-FF synchroniser, then is XORed with `RX_INVERT` to give `rxs` (logical line, idle = 1).
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. A bit counter and a cycle counter of width `$clog2(CYCLES_PER_BIT)` run alongside it.
- **IDLE:** `rxs`=0 → START, cycle counter cleared.
- **START:** at count `CYCLES_PER_BIT/2-1`, sample `rxs`.
  - 0 → DATA.
  - 1 → false start, go to IDLE with no output.
- **DATA:** sample every `CYCLES_PER_BIT` cycles, shifting LSB first.
  - After `PAYLOAD_BITS` samples: go to PARITY, or to STOP if `PARITY`=0.
- **PARITY:** one sample.
  - Error if the popcount of data+parity bit is odd for even parity, or even for odd parity.
- **STOP:** `STOP_BITS` samples.
  - All 1 → next cycle: pulse `uart_rx_valid`, load `uart_rx_data`, and drive `uart_rx_parity_err`. Then go to IDLE.
  - First stop sample 0 with data==0 and parity sample 0 (or `PARITY`=0) → pulse `uart_rx_break` (no valid), go to WAIT_IDLE.
  - Any stop sample 0 otherwise → pulse `uart_rx_frame_err` (no valid, data unchanged), go to WAIT_IDLE.
- **WAIT_IDLE:** requires `rxs`=1 continuously for `IDLE_BITS*CYCLES_PER_BIT` cycles, then goes to IDLE. Any 0 restarts the count.
- **Reset (asynchronous assertion):** state = WAIT_IDLE, counters 0, all outputs 0 including `uart_rx_data`.
  - Reset mid-character abandons that character; nothing is emitted for it.
- Pulses never overlap: at most one of valid/break/frame_err per character.

## Timing
- Pin-to-`rxs` latency is 2 cycles.
- Sample points are `CYCLES_PER_BIT/2 + k*CYCLES_PER_BIT` cycles after start-edge detection, for k = 0 … last stop bit.
- `uart_rx_valid` rises exactly 1 cycle after the last stop-bit sample. The receiver is back in IDLE in that same cycle, so a start edge arriving during the pulse is accepted.
- The minimum spacing between consecutive valid pulses is one character time, (1+PAYLOAD_BITS+parity+STOP_BITS)·CYCLES_PER_BIT cycles (6000 at defaults).
- All outputs are registered; no combinational path from `uart_rxd`.

## Structure
- Package `sbus_uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN` constants;
  - a `cycles_per_bit` function.
- One sub-module: `rx_sync_2ff`, the 2-flop synchroniser with reset value equal to the idle pin level (`RX_INVERT`).

## Test plan
Defaults apply (500 cycles/bit, inverted pin); stimulus is driven on the pin.
- **Good byte:** send 0x0F with parity 0 and two stop bits → one `uart_rx_valid` pulse 1 cycle after the 2nd stop sample, `uart_rx_data`=0x0F, `uart_rx_parity_err`=0.
- **Bad parity:** send 0x0F with parity bit 1 → valid pulse, data=0x0F, `uart_rx_parity_err`=1 in the same cycle.
- **Bad stop bit:** send 0xA5 with correct parity and first stop bit 0 → `uart_rx_frame_err` pulse, no valid, data keeps its previous value. A following 0x3C after 2 idle bits is received correctly.
- **Break:** hold the line at logical 0 for 15 bit times → exactly one `uart_rx_break`, no valid. Then 2 idle bits and 0x00 → valid with data=0x00.
- **Glitch:** logical-0 pulse of 100 cycles on an idle line → no output pulses; the FSM returns to IDLE.
- **Reset mid-byte:** assert `sw_0` low during bit 4 of 0x00 → all outputs 0 asynchronously. Release, idle 3 bit times, send 0x55 → a single valid with data=0x55.

Source files
------------

// File: rtl/sbus_uart_pkg.sv
// rtl/sbus_uart_pkg.sv - shared constants and helpers for the S.BUS UART receiver
package sbus_uart_pkg;

  // Receiver FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Whole system clocks per line bit (truncating)
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sbus_uart_rx_sync.sv
// rtl/sbus_uart_rx_sync.sv - two-flop synchroniser for the raw serial pin
module rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resets to the idle pin level so the decoder sees an idle line out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sbus_uart_rx.sv
// rtl/sbus_uart_rx.sv - oversampling UART receiver with parity, framing and BREAK detection
module sbus_uart_rx
  import sbus_uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 100_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 2,
  parameter int PARITY       = 2,
  parameter int RX_INVERT    = 1,
  parameter int IDLE_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    sw_0,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_break,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS + STOP_BITS + IDLE_BITS + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CPB_M1    = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] LAST_IDLE = BW'(IDLE_BITS - 1);

  // Pin level when the line is idle, before inversion
  localparam logic INV      = (RX_INVERT != 0);
  localparam logic IDLE_PIN = ~INV;

  logic                    rx_sync;
  logic                    rxs;
  logic [2:0]              state;
  logic [CW-1:0]           cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PAYLOAD_BITS-1:0] shift;
  logic                    par_bit;
  logic                    par_err_q;
  logic                    par_calc;

  rx_sync_2ff #(
    .RESET_VAL(IDLE_PIN)
  ) u_sync (
    .clk  (clk),
    .rst_n(sw_0),
    .d    (uart_rxd),
    .q    (rx_sync)
  );

  assign rxs      = rx_sync ^ INV;
  assign par_calc = ^{shift, rxs};

  // Character recovery FSM; pulse outputs default low every cycle
  always_ff @(posedge clk or negedge sw_0) begin
    if (!sw_0) begin
      state              <= ST_WAIT_IDLE;
      cnt                <= '0;
      bit_cnt            <= '0;
      shift              <= '0;
      par_bit            <= 1'b0;
      par_err_q          <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_valid      <= 1'b0;
      uart_rx_break      <= 1'b0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
    end else begin
      uart_rx_valid      <= 1'b0;
      uart_rx_break      <= 1'b0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CPB_M1) begin
            cnt   <= '0;
            shift <= {rxs, shift[PAYLOAD_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY == PARITY_NONE) begin
                par_bit   <= 1'b0;
                par_err_q <= 1'b0;
                state     <= ST_STOP;
              end else begin
                state <= ST_PARITY;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == CPB_M1) begin
            cnt       <= '0;
            par_bit   <= rxs;
            par_err_q <= (PARITY == PARITY_ODD) ? ~par_calc : par_calc;
            state     <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CPB_M1) begin
            cnt <= '0;
            if (!rxs) begin
              // All-zero character running into the stop bit is a BREAK
              if (bit_cnt == '0 && shift == '0 && !par_bit) uart_rx_break <= 1'b1;
              else uart_rx_frame_err <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_WAIT_IDLE;
            end else if (bit_cnt == LAST_STOP) begin
              uart_rx_valid      <= 1'b1;
              uart_rx_data       <= shift;
              uart_rx_parity_err <= par_err_q;
              bit_cnt            <= '0;
              state              <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!rxs) begin
            cnt     <= '0;
            bit_cnt <= '0;
          end else if (cnt == CPB_M1) begin
            cnt <= '0;
            if (bit_cnt == LAST_IDLE) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
          state   <= ST_WAIT_IDLE;
        end
      endcase
    end
  end

endmodule
